// File: rtl/dnpcie_aurora_tx_arb_pkg.sv
// Shared types and widths for the Aurora transmit arbiter.
package dnpcie_aurora_tx_arb_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned KEEP_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      FLUSH = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dnpcie_aurora_tx_arbiter_if.sv
// AXI-stream bundle between NUM_PORTS requesters, the arbiter and the Aurora core's s_axis_tx.
interface dnpcie_aurora_tx_arbiter_if
   import dnpcie_aurora_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4
) ();

   logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata;
   logic [NUM_PORTS*KEEP_W-1:0] s_axis_tkeep;
   logic [NUM_PORTS-1:0]        s_axis_tvalid;
   logic [NUM_PORTS-1:0]        s_axis_tlast;
   logic [NUM_PORTS-1:0]        s_axis_tready;
   logic [0:DATA_W-1]           m_axis_tdata;
   logic [0:KEEP_W-1]           m_axis_tkeep;
   logic                        m_axis_tvalid;
   logic                        m_axis_tlast;
   logic                        m_axis_tready;

   // Arbiter view.
   modport master (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
   );

   // Requester/core view.
   modport slave (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
   );

endinterface

// File: rtl/dnpcie_aurora_arb_pick.sv
// Combinational winner selection: round robin after last_grant, or fixed lowest-index
// priority when DNPCIE_AURORA_TX_ARB_STRICT_EN is defined.
module dnpcie_aurora_arb_pick #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned GRANT_W   = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [GRANT_W-1:0]   last_grant,
   output logic [GRANT_W-1:0]   winner,
   output logic                 any_req
);

   logic [GRANT_W-1:0] idx;

`ifdef DNPCIE_AURORA_TX_ARB_STRICT_EN
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   // Scan from the top so the lowest requesting index overwrites last.
   always_comb begin
      winner  = '0;
      idx     = '0;
      any_req = |req;
      for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
         idx = GRANT_W'(i);
         if (req[idx]) winner = idx;
      end
   end
`else
   // Scan the rotated order backwards so the port nearest after last_grant wins.
   always_comb begin
      winner  = '0;
      idx     = '0;
      any_req = |req;
      for (int i = int'(NUM_PORTS); i >= 1; i--) begin
         idx = GRANT_W'((int'(last_grant) + i) % int'(NUM_PORTS));
         if (req[idx]) winner = idx;
      end
   end
`endif

endmodule

// File: rtl/dnpcie_aurora_tx_arbiter.sv
// Packet-granular arbiter sharing the Aurora 16-bit TX stream among NUM_PORTS requesters.
// Define DNPCIE_AURORA_TX_ARB_STRICT_EN for fixed lowest-index priority instead of round robin.
module dnpcie_aurora_tx_arbiter
   import dnpcie_aurora_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic                         user_clk,
   input  logic                         ext_reset,
   input  logic                         channel_up,
   input  logic                         rx_nfc_xoff,
   dnpcie_aurora_tx_arbiter_if.master   bus,
   output logic [$clog2(NUM_PORTS)-1:0] grant,
   output logic                         busy,
   output logic                         length_err,
   output logic                         abort
);

   localparam int unsigned GRANT_W = $clog2(NUM_PORTS);
   localparam int unsigned CNT_W   = $clog2(MAX_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

   arb_state_e         state_q, state_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [GRANT_W-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic               length_err_q, length_err_d;
   logic               abort_q, abort_d;
   logic               busy_q, busy_d;

   logic [GRANT_W-1:0] winner;
   logic               any_req;
   logic [DATA_W-1:0]  sel_data;
   logic [KEEP_W-1:0]  sel_keep;
   logic               sel_valid;
   logic               sel_last;
   logic               at_limit;

   dnpcie_aurora_arb_pick #(
      .NUM_PORTS (NUM_PORTS),
      .GRANT_W   (GRANT_W)
   ) u_pick (
      .req        (bus.s_axis_tvalid),
      .last_grant (last_grant_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   // Mux of the currently granted port.
   always_comb begin
      sel_data  = '0;
      sel_keep  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         if (grant_q == GRANT_W'(p)) begin
            sel_data  = bus.s_axis_tdata[p*DATA_W +: DATA_W];
            sel_keep  = bus.s_axis_tkeep[p*KEEP_W +: KEEP_W];
            sel_valid = bus.s_axis_tvalid[p];
            sel_last  = bus.s_axis_tlast[p];
         end
      end
   end

   assign at_limit = (word_cnt_q == CNT_LAST);

   // Next-state and stream outputs.
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      last_grant_d      = last_grant_q;
      word_cnt_d        = word_cnt_q;
      length_err_d      = 1'b0;
      abort_d           = 1'b0;
      bus.s_axis_tready = '0;
      bus.m_axis_tdata  = sel_data;
      bus.m_axis_tkeep  = sel_keep;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tlast  = 1'b0;

      case (state_q)
         IDLE: begin
            if (channel_up && !rx_nfc_xoff && any_req) begin
               grant_d      = winner;
               last_grant_d = winner;
               word_cnt_d   = '0;
               state_d      = SEND;
            end
         end
         SEND: begin
            bus.m_axis_tvalid = sel_valid;
            bus.m_axis_tlast  = sel_last | at_limit;
            // A word presented as the link drops stays upstream and is drained in FLUSH.
            bus.s_axis_tready[grant_q] = bus.m_axis_tready & channel_up;
            if (!channel_up) begin
               abort_d = 1'b1;
               state_d = FLUSH;
            end else if (sel_valid && bus.m_axis_tready) begin
               if (!at_limit) word_cnt_d = word_cnt_q + CNT_W'(1);
               if (sel_last) begin
                  state_d = IDLE;
               end else if (at_limit) begin
                  length_err_d = 1'b1;
                  state_d      = FLUSH;
               end
            end
         end
         FLUSH: begin
            bus.s_axis_tready[grant_q] = 1'b1;
            if (sel_valid && sel_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge user_clk) begin
      if (ext_reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GRANT_W'(NUM_PORTS - 1);
         word_cnt_q   <= '0;
         length_err_q <= 1'b0;
         abort_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         word_cnt_q   <= word_cnt_d;
         length_err_q <= length_err_d;
         abort_q      <= abort_d;
         busy_q       <= busy_d;
      end
   end

   assign grant      = grant_q;
   assign busy       = busy_q;
   assign length_err = length_err_q;
   assign abort      = abort_q;

endmodule

// File: tb/tb_dnpcie_aurora_tx_arbiter.sv
// Self-checking bench for dnpcie_aurora_tx_arbiter against a packet-level reference model.
module tb_dnpcie_aurora_tx_arbiter;

   localparam int NP = 4;
   localparam int MW = 8;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  k;
      logic        l;
   } word_t;

   logic       user_clk = 1'b0;
   logic       ext_reset;
   logic       channel_up;
   logic       rx_nfc_xoff;
   logic [1:0] grant;
   logic       busy;
   logic       length_err;
   logic       abort;

   dnpcie_aurora_tx_arbiter_if #(.NUM_PORTS(NP)) bus ();

   dnpcie_aurora_tx_arbiter #(
      .NUM_PORTS (NP),
      .MAX_WORDS (MW)
   ) dut (
      .user_clk    (user_clk),
      .ext_reset   (ext_reset),
      .channel_up  (channel_up),
      .rx_nfc_xoff (rx_nfc_xoff),
      .bus         (bus.master),
      .grant       (grant),
      .busy        (busy),
      .length_err  (length_err),
      .abort       (abort)
   );

   always #5 user_clk = ~user_clk;

   int    n_tests = 0;
   int    n_fail  = 0;
   word_t srcq [NP][$];
   word_t modq [NP][$];
   int    plen [NP][$];
   word_t outq [$];
   word_t expq [$];
   int    model_last = NP - 1;
   int    exp_le = 0;
   int    le_cnt = 0;
   int    ab_cnt = 0;
   int    rdy_mode = 0;
   bit    rnd_xoff = 1'b0;
   logic  rdy_tgl = 1'b0;
   logic  prev_stall = 1'b0;
   word_t prev_w = '0;
   int    used;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int p, input int len, input bit modelled);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.d = 16'($urandom);
         w.k = 2'($urandom);
         w.l = (i == len - 1);
         srcq[p].push_back(w);
         if (modelled) modq[p].push_back(w);
      end
      if (modelled) plen[p].push_back(len);
   endtask

   // Order pending packets by arbitration policy; cut each at MW words with forced tlast.
   task automatic build_expected();
      int    p;
      int    len;
      word_t w;
      while (1) begin
         p = -1;
`ifdef DNPCIE_AURORA_TX_ARB_STRICT_EN
         for (int i = NP - 1; i >= 0; i--) if (plen[i].size() > 0) p = i;
`else
         for (int i = NP; i >= 1; i--) if (plen[(model_last + i) % NP].size() > 0) p = (model_last + i) % NP;
`endif
         if (p < 0) break;
         len = plen[p].pop_front();
         model_last = p;
         for (int j = 0; j < len; j++) begin
            w = modq[p].pop_front();
            if (j < MW) begin
               if (j == MW - 1) w.l = 1'b1;
               expq.push_back(w);
            end
         end
         if (len > MW) exp_le++;
      end
   endtask

   function automatic bit src_pending();
      bit r = 1'b0;
      for (int p = 0; p < NP; p++) if (srcq[p].size() > 0) r = 1'b1;
      return r;
   endfunction

   // One clock: drive sources from queues, sample at negedge, pop handshaken words after the edge.
   task automatic cycle();
      logic [NP-1:0] pop;
      word_t         cur;
      for (int p = 0; p < NP; p++) begin
         bus.s_axis_tvalid[p] = (srcq[p].size() > 0);
         if (srcq[p].size() > 0) begin
            bus.s_axis_tdata[16*p +: 16] = srcq[p][0].d;
            bus.s_axis_tkeep[2*p +: 2]   = srcq[p][0].k;
            bus.s_axis_tlast[p]          = srcq[p][0].l;
         end else begin
            bus.s_axis_tdata[16*p +: 16] = '0;
            bus.s_axis_tkeep[2*p +: 2]   = '0;
            bus.s_axis_tlast[p]          = 1'b0;
         end
      end
      case (rdy_mode)
         1:       bus.m_axis_tready = ($urandom_range(3) != 0);
         2:       begin rdy_tgl = ~rdy_tgl; bus.m_axis_tready = rdy_tgl; end
         default: bus.m_axis_tready = 1'b1;
      endcase
      if (rnd_xoff) rx_nfc_xoff = ($urandom_range(4) == 0);

      @(negedge user_clk);
      cur = word_t'({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast});
      if (prev_stall) begin
         chk("hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
         chk("hold_word", 32'(cur), 32'(prev_w));
      end
      if (bus.m_axis_tvalid && channel_up) begin
         chk("tready_mirror", 32'(bus.s_axis_tready[grant]), 32'(bus.m_axis_tready));
         chk("tready_others", 32'(bus.s_axis_tready & ~(NP'(1) << grant)), 32'd0);
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready && channel_up && !ext_reset;
      prev_w     = cur;
      if (bus.m_axis_tvalid && bus.m_axis_tready && channel_up) outq.push_back(cur);
      if (length_err) le_cnt++;
      if (abort) ab_cnt++;
      pop = bus.s_axis_tvalid & bus.s_axis_tready;

      @(posedge user_clk);
      #1;
      for (int p = 0; p < NP; p++) if (pop[p]) void'(srcq[p].pop_front());
   endtask

   task automatic run_pkts(input string tag, input int budget, output int n);
      int le0;
      int ab0;
      int e0;
      int m;
      le0 = le_cnt;
      ab0 = ab_cnt;
      e0  = exp_le;
      build_expected();
      n = 0;
      while ((outq.size() < expq.size() || src_pending()) && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_done"}, 32'(outq.size() >= expq.size() && !src_pending()), 32'd1);
      chk({tag, "_words"}, outq.size(), expq.size());
      m = (outq.size() < expq.size()) ? outq.size() : expq.size();
      for (int i = 0; i < m; i++) chk({tag, "_word"}, 32'(outq[i]), 32'(expq[i]));
      chk({tag, "_length_err"}, le_cnt - le0, exp_le - e0);
      chk({tag, "_abort"}, ab_cnt - ab0, 0);
      outq.delete();
      expq.delete();
      cycle();
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ext_reset          = 1'b1;
      channel_up         = 1'b1;
      rx_nfc_xoff        = 1'b0;
      bus.m_axis_tready  = 1'b1;
      bus.s_axis_tvalid  = '0;
      bus.s_axis_tlast   = '0;
      bus.s_axis_tdata   = '0;
      bus.s_axis_tkeep   = '0;
      repeat (3) cycle();

      // Reset values
      @(negedge user_clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_s_tready", 32'(bus.s_axis_tready), 32'd0);
      chk("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      chk("rst_length_err", 32'(length_err), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      @(posedge user_clk);
      #1;
      ext_reset = 1'b0;

      // Round robin, four 4-word packets at full rate: 4*(4+1) cycles
      for (int p = 0; p < NP; p++) add_pkt(p, 4, 1'b1);
      run_pkts("rr", 200, used);
      chk("rr_cycles", used, 20);

      // Backpressure with toggling ready
      rdy_mode = 2;
      rdy_tgl  = 1'b0;
      add_pkt(1, 3, 1'b1);
      run_pkts("bp", 100, used);
      rdy_mode = 0;

      // Truncation then exact-limit packet
      add_pkt(2, 12, 1'b1);
      run_pkts("trunc", 100, used);
      add_pkt(2, MW, 1'b1);
      run_pkts("exact", 100, used);

      // XOFF blocks new grants only
      rx_nfc_xoff = 1'b1;
      add_pkt(3, 6, 1'b1);
      repeat (4) begin
         cycle();
         chk("xoff_block", 32'(busy), 32'd0);
      end
      rx_nfc_xoff = 1'b0;
      cycle();
      chk("xoff_grant_busy", 32'(busy), 32'd1);
      chk("xoff_grant_port", 32'(grant), 32'd3);
      chk("xoff_grant_valid", 32'(bus.m_axis_tvalid), 32'd1);
      rx_nfc_xoff = 1'b1;
      cycle();
      run_pkts("xoff", 100, used);
      rx_nfc_xoff = 1'b0;

      // Link loss mid-packet
      add_pkt(0, 10, 1'b0);
      used = 0;
      while (outq.size() < 2 && used < 20) begin
         cycle();
         used++;
      end
      chk("ll_reach", outq.size(), 2);
      channel_up = 1'b0;
      cycle();
      chk("ll_abort", 32'(abort), 32'd1);
      chk("ll_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      chk("ll_busy", 32'(busy), 32'd1);
      cycle();
      chk("ll_abort_pulse", 32'(abort), 32'd0);
      used = 0;
      while (srcq[0].size() > 0 && used < 30) begin
         cycle();
         used++;
      end
      chk("ll_drained", srcq[0].size(), 0);
      cycle();
      chk("ll_idle", 32'(busy), 32'd0);
      chk("ll_outq", outq.size(), 2);
      chk("ll_abort_cnt", ab_cnt, 1);
      outq.delete();
      add_pkt(1, 5, 1'b1);
      repeat (5) begin
         cycle();
         chk("ll_no_grant", 32'(busy), 32'd0);
      end
      model_last = 0;
      ab_cnt     = 0;
      channel_up = 1'b1;
      run_pkts("ll_resume", 100, used);

      // Randomized packets, ready and XOFF
      rdy_mode = 1;
      rnd_xoff = 1'b1;
      repeat (24) add_pkt(int'($urandom_range(NP - 1)), int'($urandom_range(12, 1)), 1'b1);
      run_pkts("rand", 4000, used);
      rdy_mode    = 0;
      rnd_xoff    = 1'b0;
      rx_nfc_xoff = 1'b0;

      // Reset mid-packet returns straight to reset values
      add_pkt(2, 6, 1'b0);
      repeat (3) cycle();
      chk("rstmid_busy_before", 32'(busy), 32'd1);
      ext_reset = 1'b1;
      cycle();
      ext_reset = 1'b0;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_grant", 32'(grant), 32'd0);
      chk("rstmid_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      chk("rstmid_s_tready", 32'(bus.s_axis_tready), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
